// File: rtl/param_stack_pkg.sv
// Shared types and helpers for the param_stack LIFO.
package param_stack_pkg;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPL,
        OP_TOP
    } op_e;

    // Occupancy must represent 0..DEPTH inclusive, hence DEPTH+1 states.
    function automatic int calc_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/param_stack_mem.sv
// Storage array for param_stack: synchronous write port plus registered read port.
// A read and a write to the same address on one edge return the old contents.
module param_stack_mem
    import param_stack_pkg::*;
#(
    parameter int WIDTH = 23,
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    // NOTE: the array has no reset so it can map onto RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read samples the pre-edge array, giving read-before-write on a replace.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO with status flags, error reporting and registered read data.
// Define PARAM_STACK_STICKY_ERR_EN for sticky overflow/underflow with an err_clr input.
module param_stack
    import param_stack_pkg::*;
#(
    parameter int WIDTH = 23,
    parameter int DEPTH = 128,
    parameter int CW    = calc_cw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PARAM_STACK_STICKY_ERR_EN
    input  logic             err_clr,
`endif
    input  logic [WIDTH-1:0] in,
    input  logic             push,
    input  logic             pop,
    input  logic             top,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    op_e           op;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          out_valid_q, out_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          ovf_evt, udf_evt;
    logic          wr_en, rd_en;
    logic [AW-1:0] wr_addr, top_addr;

    // Wraps when empty, but is only used when the stack holds at least one entry.
    assign top_addr = AW'(count_q - CW'(1));

    always_comb begin
        unique case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_REPL;
            default: op = top ? OP_TOP : OP_IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = AW'(count_q);
        rd_en   = 1'b0;
        ovf_evt = 1'b0;
        udf_evt = 1'b0;
        unique case (op)
            OP_PUSH: begin
                if (full_q) begin
                    ovf_evt = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            OP_POP: begin
                if (empty_q) begin
                    udf_evt = 1'b1;
                end else begin
                    rd_en   = 1'b1;
                    count_d = count_q - CW'(1);
                end
            end
            OP_REPL: begin
                wr_en = 1'b1;
                if (empty_q) begin
                    udf_evt = 1'b1;
                    count_d = CW'(1);
                end else begin
                    rd_en   = 1'b1;
                    wr_addr = top_addr;
                end
            end
            OP_TOP: begin
                if (empty_q) begin
                    udf_evt = 1'b1;
                end else begin
                    rd_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        full_d      = (count_d == CW'(DEPTH));
        empty_d     = (count_d == '0);
        out_valid_d = rd_en;
`ifdef PARAM_STACK_STICKY_ERR_EN
        // A new error event wins over a clear on the same edge.
        overflow_d  = ovf_evt | (overflow_q  & ~err_clr);
        underflow_d = udf_evt | (underflow_q & ~err_clr);
`else
        overflow_d  = ovf_evt;
        underflow_d = udf_evt;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    param_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (in),
        .rd_en   (rd_en),
        .rd_addr (top_addr),
        .rd_data (out)
    );

    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack: directed vector table, reset sequence, random run vs queue model.
// Honours PARAM_STACK_STICKY_ERR_EN to match the DUT build.
module tb_param_stack;

    localparam int WIDTH = 23;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in;
    logic             push, pop, top;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [CW-1:0]    count;
    logic             full, empty, overflow, underflow;
`ifdef PARAM_STACK_STICKY_ERR_EN
    logic             err_clr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    param_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PARAM_STACK_STICKY_ERR_EN
        .err_clr   (err_clr),
`endif
        .in        (in),
        .push      (push),
        .pop       (pop),
        .top       (top),
        .out       (out),
        .out_valid (out_valid),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Behavioural model: a queue whose back is the top of stack.
    logic [WIDTH-1:0] m_stk [$];
    logic [WIDTH-1:0] m_out;
    logic             m_valid, m_ovf, m_udf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stk.delete();
        m_out   = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic q, input logic t, input logic [WIDTH-1:0] d);
        logic ovf_e = 1'b0;
        logic udf_e = 1'b0;
        m_valid = 1'b0;
        if (p && !q) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(d);
            else ovf_e = 1'b1;
        end else if (q && !p) begin
            if (m_stk.size() > 0) begin
                m_out   = m_stk.pop_back();
                m_valid = 1'b1;
            end else udf_e = 1'b1;
        end else if (p && q) begin
            if (m_stk.size() > 0) begin
                m_out = m_stk[m_stk.size() - 1];
                m_stk[m_stk.size() - 1] = d;
                m_valid = 1'b1;
            end else begin
                udf_e = 1'b1;
                m_stk.push_back(d);
            end
        end else if (t) begin
            if (m_stk.size() > 0) begin
                m_out   = m_stk[m_stk.size() - 1];
                m_valid = 1'b1;
            end else udf_e = 1'b1;
        end
`ifdef PARAM_STACK_STICKY_ERR_EN
        m_ovf = ovf_e | (m_ovf & ~err_clr);
        m_udf = udf_e | (m_udf & ~err_clr);
`else
        m_ovf = ovf_e;
        m_udf = udf_e;
`endif
    endtask

    task automatic compare_model();
        check("out",       32'(out),       32'(m_out));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("count",     32'(count),     m_stk.size());
        check("full",      32'(full),      32'(m_stk.size() == DEPTH));
        check("empty",     32'(empty),     32'(m_stk.size() == 0));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_udf));
    endtask

    // Called at a negedge: drive, take one rising edge, check 1 ns later, return at the next negedge.
    task automatic cycle(input logic p, input logic q, input logic t, input logic [WIDTH-1:0] d);
        push = p; pop = q; top = t; in = d;
        @(posedge clk);
        #1;
        model_step(p, q, t, d);
        compare_model();
        @(negedge clk);
    endtask

    typedef struct {
        logic             push, pop, top;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp_out;
        logic             exp_valid;
        int               exp_count;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic p, input logic q, input logic t, input logic [WIDTH-1:0] d,
                                input logic [WIDTH-1:0] eo, input logic ev, input int ec);
        vec_t v;
        v.push = p; v.pop = q; v.top = t; v.din = d;
        v.exp_out = eo; v.exp_valid = ev; v.exp_count = ec;
        return v;
    endfunction

    initial begin
        // LIFO order
        vecs.push_back(mk(1, 0, 0, 23'h000011, 23'h000000, 0, 1));
        vecs.push_back(mk(1, 0, 0, 23'h000022, 23'h000000, 0, 2));
        vecs.push_back(mk(1, 0, 0, 23'h000033, 23'h000000, 0, 3));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h000033, 1, 2));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h000022, 1, 1));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h000011, 1, 0));
        // Fill, overflow, drain
        vecs.push_back(mk(1, 0, 0, 23'h000001, 23'h000011, 0, 1));
        vecs.push_back(mk(1, 0, 0, 23'h000002, 23'h000011, 0, 2));
        vecs.push_back(mk(1, 0, 0, 23'h000003, 23'h000011, 0, 3));
        vecs.push_back(mk(1, 0, 0, 23'h000004, 23'h000011, 0, 4));
        vecs.push_back(mk(1, 0, 0, 23'h7FFFFF, 23'h000011, 0, 4));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h000004, 1, 3));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h000003, 1, 2));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h000002, 1, 1));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h000001, 1, 0));
        // Empty-stack errors and replace-on-empty
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h000001, 0, 0));
        vecs.push_back(mk(0, 0, 1, 23'h0,      23'h000001, 0, 0));
        vecs.push_back(mk(1, 1, 0, 23'h000055, 23'h000001, 0, 1));
        vecs.push_back(mk(0, 0, 1, 23'h0,      23'h000055, 1, 1));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h000055, 1, 0));
        // Replace returns old top
        vecs.push_back(mk(1, 0, 0, 23'h00000A, 23'h000055, 0, 1));
        vecs.push_back(mk(1, 0, 0, 23'h00000B, 23'h000055, 0, 2));
        vecs.push_back(mk(1, 1, 0, 23'h00000C, 23'h00000B, 1, 2));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h00000C, 1, 1));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h00000A, 1, 0));
        // Repeated peek, then idle holds out
        vecs.push_back(mk(1, 0, 0, 23'h000001, 23'h00000A, 0, 1));
        vecs.push_back(mk(1, 0, 0, 23'h000002, 23'h00000A, 0, 2));
        vecs.push_back(mk(0, 0, 1, 23'h0,      23'h000002, 1, 2));
        vecs.push_back(mk(0, 0, 1, 23'h0,      23'h000002, 1, 2));
        vecs.push_back(mk(0, 0, 0, 23'h0,      23'h000002, 0, 2));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h000002, 1, 1));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h000001, 1, 0));
        // Replace while full is legal
        vecs.push_back(mk(1, 0, 0, 23'h000005, 23'h000001, 0, 1));
        vecs.push_back(mk(1, 0, 0, 23'h000006, 23'h000001, 0, 2));
        vecs.push_back(mk(1, 0, 0, 23'h000007, 23'h000001, 0, 3));
        vecs.push_back(mk(1, 0, 0, 23'h000008, 23'h000001, 0, 4));
        vecs.push_back(mk(1, 1, 0, 23'h000009, 23'h000008, 1, 4));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h000009, 1, 3));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h000007, 1, 2));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h000006, 1, 1));
        vecs.push_back(mk(0, 1, 0, 23'h0,      23'h000005, 1, 0));

        rst = 1'b1; push = 1'b0; pop = 1'b0; top = 1'b0; in = '0;
`ifdef PARAM_STACK_STICKY_ERR_EN
        err_clr = 1'b0;
`endif
        model_reset();
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full",  32'(full),  0);
        check("rst_out",   32'(out),   0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            cycle(vecs[i].push, vecs[i].pop, vecs[i].top, vecs[i].din);
            check($sformatf("vec%0d_out", i),   32'(out),       32'(vecs[i].exp_out));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_count", i), 32'(count),     vecs[i].exp_count);
        end

        // Asynchronous reset between edges after three pushes
        cycle(1, 0, 0, 23'h000111);
        cycle(1, 0, 0, 23'h000222);
        cycle(1, 0, 0, 23'h000333);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_count",     32'(count),     0);
        check("arst_out",       32'(out),       0);
        check("arst_valid",     32'(out_valid), 0);
        check("arst_full",      32'(full),      0);
        check("arst_empty",     32'(empty),     1);
        check("arst_overflow",  32'(overflow),  0);
        check("arst_underflow", 32'(underflow), 0);
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 1, 0, '0);
        check("arst_pop_udf", 32'(underflow), 1);
        cycle(0, 0, 0, '0);
`ifdef PARAM_STACK_STICKY_ERR_EN
        check("sticky_hold", 32'(underflow), 1);
        err_clr = 1'b1;
        cycle(0, 0, 0, '0);
        err_clr = 1'b0;
        check("sticky_clr", 32'(underflow), 0);
`else
        check("pulse_drop", 32'(underflow), 0);
`endif

        // Randomised traffic against the model
        for (int n = 0; n < 800; n++) begin
            int sel = $urandom_range(0, 9);
            logic [WIDTH-1:0] d = WIDTH'($urandom);
`ifdef PARAM_STACK_STICKY_ERR_EN
            err_clr = ($urandom_range(0, 7) == 0);
`endif
            if (sel < 4)       cycle(1, 0, 0, d);
            else if (sel < 7)  cycle(0, 1, 0, d);
            else if (sel == 7) cycle(1, 1, 0, d);
            else if (sel == 8) cycle(0, 0, 1, d);
            else               cycle(0, 0, 0, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
